mac_array_gen: RTL and testbench

Parametrised multi-lane multiply-accumulate engine. It is the next generation of the fixed four-lane, 7×8-bit MAC ALU used between the input row buffer and the output writer. Each accepted beat multiplies one coefficient field by one data element per lane and accumulates the product. After `K` beats a group result is emitted through a valid/ready output register; after `N_GROUP` groups the matrix is complete. Adds input/output handshakes, output backpressure, optional saturation with per-lane sticky overflow, and last/done signalling.

---
 rtl/mac_array_gen.sv | 143 ++++++++++++++
 tb/tb_mac_array_gen.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_gen.sv
// Parametrised multi-lane multiply-accumulate engine with valid/ready
// input and output handshakes, optional saturation and matrix sequencing.
module mac_array_gen #(
    parameter int N_LANE  = 4,
    parameter int DW      = 8,
    parameter int CW      = 7,
    parameter int CPW     = 2,
    parameter int K       = 8,
    parameter int N_GROUP = 4,
    parameter int AW      = 18,
    parameter int SAT     = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [CPW*CW-1:0]                     coef_word,
    output logic [$clog2(N_GROUP*K/CPW)-1:0]      coef_addr,
    input  logic [N_LANE*DW-1:0]                  x_in,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic                                  x_shift,
    output logic [N_LANE*AW-1:0]                  acc_out,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  out_last,
    output logic [N_LANE-1:0]                     ovf,
    output logic                                  busy,
    output logic                                  done
);

    localparam int CAW = $clog2(N_GROUP*K/CPW);
    localparam int BW  = (K > 1) ? $clog2(K) : 1;
    localparam int GW  = (N_GROUP > 1) ? $clog2(N_GROUP) : 1;
    localparam int FW  = (CPW > 1) ? $clog2(CPW) : 1;
    localparam int PW  = CW + DW;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_nx;

    logic [BW-1:0] beat_cnt;
    logic [GW-1:0] group_cnt;
    logic [FW-1:0] fld_cnt;
    logic [N_LANE-1:0][AW-1:0] acc;
    logic [N_LANE-1:0][AW-1:0] res;
    logic [N_LANE-1:0][AW:0]   sum;
    logic [N_LANE-1:0][PW-1:0] prod;
    logic [N_LANE-1:0]         ovf_now;
    logic [CW-1:0]             coef;
    logic accept, last_beat, last_group;

    assign last_beat  = (beat_cnt == BW'(K - 1));
    assign last_group = (group_cnt == GW'(N_GROUP - 1));
    assign in_ready   = (state == RUN) &&
                        !(last_beat && out_valid && !out_ready);
    assign accept     = in_valid && in_ready;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    // field 0 sits in the MSBs of the coefficient word
    assign coef = coef_word[(CPW - 1 - int'(fld_cnt)) * CW +: CW];

    always_comb begin
        prod    = '0;
        sum     = '0;
        res     = '0;
        ovf_now = '0;
        for (int l = 0; l < N_LANE; l++) begin
            prod[l]    = PW'(coef) * PW'(x_in[l*DW +: DW]);
            sum[l]     = {1'b0, acc[l]} + (AW+1)'(prod[l]);
            ovf_now[l] = sum[l][AW];
            if (sum[l][AW] && (SAT != 0))
                res[l] = '1;
            else
                res[l] = sum[l][AW-1:0];
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = RUN;
            RUN:   if (accept && last_beat && last_group) state_nx = DRAIN;
            DRAIN: if (out_valid && out_ready) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            group_cnt <= '0;
            fld_cnt   <= '0;
            coef_addr <= '0;
            acc       <= '0;
            ovf       <= '0;
            x_shift   <= 1'b0;
            acc_out   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state   <= state_nx;
            x_shift <= accept;
            if (state == IDLE && start) begin
                beat_cnt  <= '0;
                group_cnt <= '0;
                fld_cnt   <= '0;
                coef_addr <= '0;
                acc       <= '0;
                ovf       <= '0;
            end else if (accept) begin
                ovf <= ovf | ovf_now;
                if (fld_cnt == FW'(CPW - 1)) begin
                    fld_cnt <= '0;
                    // hold the address on the very last word of the matrix
                    if (!(last_beat && last_group))
                        coef_addr <= coef_addr + CAW'(1);
                end else begin
                    fld_cnt <= fld_cnt + FW'(1);
                end
                if (last_beat) begin
                    beat_cnt  <= '0;
                    acc       <= '0;
                    group_cnt <= last_group ? '0 : group_cnt + GW'(1);
                end else begin
                    beat_cnt <= beat_cnt + BW'(1);
                    acc      <= res;
                end
            end
            if (accept && last_beat) begin
                acc_out   <= res;
                out_valid <= 1'b1;
                out_last  <= last_group;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_array_gen.sv
// Randomised scoreboard bench for mac_array_gen plus two narrow
// instances exercising saturating and wrapping overflow.
module tb_mac_array_gen;

    localparam int NL  = 4;
    localparam int DW  = 8;
    localparam int CW  = 7;
    localparam int CPW = 2;
    localparam int K   = 8;
    localparam int NG  = 4;
    localparam int AW  = 18;
    localparam int NB  = NG * K;
    localparam int NW  = NB / CPW;

    typedef struct {
        logic [NL*AW-1:0] acc;
        logic             last;
    } exp_t;

    logic clk = 1'b0;
    logic rst, start;
    logic [CPW*CW-1:0] coef_word;
    logic [3:0] coef_addr;
    logic [NL*DW-1:0] x_in;
    logic in_valid, in_ready, x_shift;
    logic [NL*AW-1:0] acc_out;
    logic out_valid, out_ready, out_last;
    logic [NL-1:0] ovf;
    logic busy, done;

    logic s_start;
    logic [3:0] s_addr, w_addr;
    logic s_inr, s_xs, s_ov, s_ol, s_busy, s_done;
    logic w_inr, w_xs, w_ov, w_ol, w_busy, w_done;
    logic [NL*16-1:0] s_acc, w_acc;
    logic [NL-1:0] s_ovf, w_ovf;

    logic [CW-1:0] rom [NW][CPW];
    int xb [NB][NL];
    exp_t q[$];
    exp_t mon_e;

    int n_chk = 0, n_fail = 0;
    int xs_cnt, done_cnt, max_addr, beat_i, or_mode;

    always #5 clk = ~clk;

    mac_array_gen dut (
        .clk(clk), .rst(rst), .start(start),
        .coef_word(coef_word), .coef_addr(coef_addr),
        .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready),
        .x_shift(x_shift), .acc_out(acc_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .ovf(ovf), .busy(busy), .done(done)
    );

    mac_array_gen #(.AW(16), .SAT(1)) dut_s (
        .clk(clk), .rst(rst), .start(s_start),
        .coef_word({7'd127, 7'd127}), .coef_addr(s_addr),
        .x_in({NL{8'd255}}), .in_valid(1'b1), .in_ready(s_inr),
        .x_shift(s_xs), .acc_out(s_acc),
        .out_valid(s_ov), .out_ready(1'b1),
        .out_last(s_ol), .ovf(s_ovf), .busy(s_busy), .done(s_done)
    );

    mac_array_gen #(.AW(16), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .start(s_start),
        .coef_word({7'd127, 7'd127}), .coef_addr(w_addr),
        .x_in({NL{8'd255}}), .in_valid(1'b1), .in_ready(w_inr),
        .x_shift(w_xs), .acc_out(w_acc),
        .out_valid(w_ov), .out_ready(1'b1),
        .out_last(w_ol), .ovf(w_ovf), .busy(w_busy), .done(w_done)
    );

    always_comb begin
        coef_word = '0;
        for (int f = 0; f < CPW; f++)
            coef_word[(CPW-1-f)*CW +: CW] = rom[coef_addr][f];
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // scoreboard monitor: compares whenever a result is handshaken
    always @(negedge clk) begin
        if (!rst) begin
            if (x_shift) xs_cnt++;
            if (done) done_cnt++;
            if (int'(coef_addr) > max_addr) max_addr = int'(coef_addr);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    mon_e = q.pop_front();
                    chk("acc_out", acc_out, mon_e.acc);
                    chk("out_last", out_last, mon_e.last);
                end
            end else if (out_valid && q.size() > 0) begin
                chk("acc_held", acc_out, q[0].acc);
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (or_mode == 0) out_ready = 1'b1;
            else if (or_mode == 1) out_ready = 1'($urandom_range(0, 1));
            else out_ready = 1'b0;
        end
    end

    task automatic build(input int rk);
        int s, idx;
        exp_t e;
        for (int a = 0; a < NW; a++)
            for (int f = 0; f < CPW; f++)
                if (rk == 0) rom[a][f] = 7'd1;
                else if (rk == 1) rom[a][f] = (f == 0) ? 7'd3 : 7'd5;
                else rom[a][f] = 7'($urandom_range(0, 127));
        for (int i = 0; i < NB; i++)
            for (int l = 0; l < NL; l++)
                if (rk == 0) xb[i][l] = l + 1;
                else if (rk == 1 && l == 0) xb[i][l] = (i % 2 == 0) ? 1 : 0;
                else xb[i][l] = $urandom_range(0, 255);
        for (int g = 0; g < NG; g++) begin
            e.acc = '0;
            for (int l = 0; l < NL; l++) begin
                s = 0;
                for (int b = 0; b < K; b++) begin
                    idx = g * K + b;
                    s += int'(rom[idx / CPW][idx % CPW]) * xb[idx][l];
                end
                if (s > (1 << AW) - 1) s = (1 << AW) - 1;
                e.acc[l*AW +: AW] = AW'(s);
            end
            e.last = (g == NG - 1);
            q.push_back(e);
        end
    endtask

    task automatic feed(input int ivm, input int stop_at);
        int guard = 0;
        beat_i = 0;
        while (beat_i < stop_at && guard < 3000) begin
            @(posedge clk);
            #1;
            in_valid = (ivm != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int l = 0; l < NL; l++)
                x_in[l*DW +: DW] = DW'(xb[beat_i][l]);
            @(negedge clk);
            if (in_valid && in_ready) beat_i++;
            guard++;
        end
        if (guard >= 3000) chk("feed_timeout", beat_i, stop_at);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic kick();
        xs_cnt = 0;
        done_cnt = 0;
        max_addr = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_matrix(input int rk, input int ivm, input int stall);
        int g;
        build(rk);
        if (stall != 0) or_mode = 2;
        kick();
        chk("busy_after_start", busy, 1);
        chk("ovf_cleared", ovf, 0);
        if (stall != 0) begin
            fork
                feed(ivm, NB);
                begin
                    g = 0;
                    while (beat_i < 15 && g < 200) begin
                        @(negedge clk);
                        g++;
                    end
                    repeat (10) @(negedge clk);
                    chk("stall_beats", beat_i, 15);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_out_valid", out_valid, 1);
                    or_mode = 0;
                end
            join
        end else begin
            feed(ivm, NB);
        end
        g = 0;
        while (done_cnt == 0 && g < 400) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        chk("done_pulses", done_cnt, 1);
        chk("x_shift_count", xs_cnt, NB);
        chk("coef_addr_max", max_addr, NW - 1);
        chk("queue_drained", q.size(), 0);
        chk("busy_idle", busy, 0);
        chk("ovf_none", ovf, 0);
        q.delete();
        or_mode = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_acc_out"}, acc_out, 0);
        chk({tag, "_coef_addr"}, coef_addr, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_x_shift"}, x_shift, 0);
        chk({tag, "_out_last"}, out_last, 0);
    endtask

    initial begin
        int g;
        or_mode = 0;
        rst = 1'b1;
        start = 1'b0;
        s_start = 1'b0;
        in_valid = 1'b0;
        x_in = '0;
        build(0);
        q.delete();
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // overflow behaviour on the 16-bit instances
        @(posedge clk);
        #1;
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        g = 0;
        while (!s_ov && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("sat_acc", s_acc, {NL{16'hFFFF}});
        chk("sat_ovf", s_ovf, 4'hF);
        chk("wrap_acc", w_acc, {NL{16'd62472}});
        chk("wrap_ovf", w_ovf, 4'hF);
        g = 0;
        while (!s_done && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("sat_done", s_done, 1);

        run_matrix(0, 0, 0);
        run_matrix(1, 0, 0);
        or_mode = 1;
        run_matrix(2, 1, 0);
        run_matrix(0, 0, 1);
        run_matrix(0, 1, 0);

        // reset in the middle of group 1
        build(0);
        kick();
        feed(0, 13);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_matrix(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
